// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and limits shared by the GPIO bank.
package gpio_pkg;
    localparam int OFS_W   = 3;
    localparam int NCH_MAX = 8;
    localparam logic [OFS_W-1:0] GPIO_OUT  = 3'd0;
    localparam logic [OFS_W-1:0] GPIO_SET  = 3'd1;
    localparam logic [OFS_W-1:0] GPIO_CLR  = 3'd2;
    localparam logic [OFS_W-1:0] GPIO_IN   = 3'd3;
    localparam logic [OFS_W-1:0] GPIO_DIR  = 3'd4;
    localparam logic [OFS_W-1:0] GPIO_IE   = 3'd5;
    localparam logic [OFS_W-1:0] GPIO_IS   = 3'd6;
    localparam logic [OFS_W-1:0] GPIO_EDGE = 3'd7;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-wide multi-flop input synchroniser with async reset.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] ff;
    always_ff @(posedge clk or posedge rst)
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO with set/clear, synchronised inputs and edge interrupts.
// Define GPIO_IRQ_EN to build IE/IS/EDGE registers and the irq line.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int AW          = $clog2(NCH) + OFS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        a,
    input  logic [WIDTH-1:0]     wd,
    output logic [WIDTH-1:0]     rd,
    input  logic [NCH*WIDTH-1:0] gpi,
    output logic [NCH*WIDTH-1:0] gpo,
    output logic [NCH*WIDTH-1:0] gpoe,
    output logic                 irq
);
    logic [AW-1:0]    ch;
    logic [OFS_W-1:0] off;
    logic [WIDTH-1:0] rv [NCH][8];
    logic [NCH-1:0]   pend;
    assign ch  = a >> OFS_W;
    assign off = a[OFS_W-1:0];
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic             sel;
        logic [WIDTH-1:0] out, dir, pin, ie, is, edg;
        assign sel = we && ch == AW'(c);
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                out <= '0;
                dir <= '0;
            end else if (sel) begin
                out <= off == GPIO_OUT ? wd : off == GPIO_SET ? out | wd : off == GPIO_CLR ? out & ~wd : out;
                dir <= off == GPIO_DIR ? wd : dir;
            end
        gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (gpi[c*WIDTH +: WIDTH]),
            .q   (pin)
        );
`ifdef GPIO_IRQ_EN
        logic [WIDTH-1:0] prev, ev;
        assign ev = ~dir & ((edg & prev & ~pin) | (~edg & pin & ~prev));
        // a new event overrides a same-cycle write-1-to-clear
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                prev <= '0;
                ie   <= '0;
                is   <= '0;
                edg  <= '0;
            end else begin
                prev <= pin;
                ie   <= sel && off == GPIO_IE ? wd : ie;
                edg  <= sel && off == GPIO_EDGE ? wd : edg;
                is   <= (is & ~(sel && off == GPIO_IS ? wd : '0)) | ev;
            end
`else
        assign ie  = '0;
        assign is  = '0;
        assign edg = '0;
`endif
        assign rv[c][0] = out;
        assign rv[c][1] = out;
        assign rv[c][2] = out;
        assign rv[c][3] = pin;
        assign rv[c][4] = dir;
        assign rv[c][5] = ie;
        assign rv[c][6] = is;
        assign rv[c][7] = edg;
        assign gpo[c*WIDTH +: WIDTH]  = out;
        assign gpoe[c*WIDTH +: WIDTH] = dir;
        assign pend[c] = |(is & ie);
    end
    always_comb begin
        rd = '0;
        for (int i = 0; i < NCH; i++) rd = ch == AW'(i) ? rv[i][off] : rd;
    end
    assign irq = |pend;
endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO peripheral: NCH channels of WIDTH pins each, with per-pin direction, atomic set/clear of outputs, synchronised inputs and per-pin edge interrupts. It sits on the processor's data-memory bus as a single-cycle slave: synchronous writes, combinational read data. It drives a single level interrupt line toward the interrupt controller.

## Interface
- WIDTH, 32, pins per channel and bus data width
- NCH, 2, number of channels (1..8)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- AW, $clog2(NCH)+3, derived address width; a = {channel, register}
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- we  input  1  write strobe
- a  input  AW  word address; a[2:0] register offset, a[AW-1:3] channel
- wd  input  WIDTH  write data
- rd  output  WIDTH  read data, combinational from a
- gpi  input  NCH*WIDTH  raw pin inputs; channel c at [c*WIDTH +: WIDTH]
- gpo  output  NCH*WIDTH  output data register
- gpoe  output  NCH*WIDTH  output enable (= DIR)
- irq  output  1  OR over all channels of (IS & IE)

## Operation
- Per-channel register map (offset: name, access):
  - 0 OUT rw; 1 OUT_SET wo (OUT |= wd), reads OUT; 2 OUT_CLR wo (OUT &= ~wd), reads OUT
  - 3 IN ro (synchronised gpi); 4 DIR rw (1 = output)
  - 5 IE rw interrupt enable; 6 IS interrupt status, write-1-to-clear; 7 EDGE rw (0 rising, 1 falling)
- Writes take effect at the clk edge with we=1; writes to IN ignored.
- Channel index >= NCH: writes ignored, rd = 0.
- Input path: gpi -> SYNC_STAGES flops -> IN; one extra flop holds prev.
- Edge event bit i: DIR[i]=0 and (EDGE[i] ? prev&~IN : IN&~prev).
- IS[i] sets on event regardless of IE; IE only gates irq.
- Simultaneous event and W1C on same bit: set wins, IS stays 1.
- Bits with DIR=1 never raise events; IN still reflects the pin.
- Changing EDGE or DIR does not itself clear IS.

## Timing
- Reset: OUT, DIR, IE, IS, EDGE, all synchroniser and prev flops = 0; hence gpo = 0, gpoe = 0, irq = 0.
- rd valid in the same cycle as a; written value readable the cycle after the write edge.
- gpo/gpoe update one cycle after the write.
- Pin change visible in IN after SYNC_STAGES edges; IS sets one edge later; irq combinational from IS/IE (no extra cycle).
- Reset asserted mid-operation clears all state immediately; no pending event survives reset.
- Pulses shorter than one clk period may be missed; this is not an error.

## Configuration
- GPIO_IRQ_EN defined: IE, IS, EDGE, prev flops and irq logic are present as above.
- Not defined: those registers are not built; offsets 5-7 read 0, writes ignored, irq tied to 0; OUT/SET/CLR/IN/DIR unchanged.

## Structure
- Package gpio_pkg: register offset constants (GPIO_OUT .. GPIO_EDGE), offset width 3, NCH upper limit.
- Sub-module gpio_sync: WIDTH-wide SYNC_STAGES flop synchroniser with async reset; one instance per channel.
- Channel registers built with generate loop; read mux indexed by channel then offset.

## Test plan
- Reset: assert rst mid-traffic -> gpo=0, gpoe=0, irq=0, every register reads 0.
- Set/clear: write OUT=0x0000_00F0, OUT_SET 0x0F, OUT_CLR 0x30 -> gpo ch0 = 0x0000_00CF, read offset 0 = 0xCF.
- Sync latency: DIR=0, toggle gpi[0] 0->1 -> IN bit0 reads 1 exactly SYNC_STAGES edges later.
- Rising IRQ: IE ch1 = 0x1, gpi ch1 bit0 rises -> IS ch1 = 0x1, irq=1; write IS=0x1 -> irq=0 next cycle.
- Falling/collision: EDGE=0x1, falling edge arriving same cycle as W1C -> IS bit0 remains 1; output bit (DIR=1) toggling -> no IS change.
- Out-of-range/config: NCH=3, access channel 3 -> rd=0, no state change; build without GPIO_IRQ_EN -> offsets 5-7 read 0, irq stuck 0.
